// File: rtl/tracker_fsm.sv
// Solar tracker sequencing controller: homes, sweeps and returns each axis to
// its brightest position using an external max counter, then holds in MAN.
module tracker_fsm #(
    parameter int unsigned      TMO_W   = 24,
    parameter logic [TMO_W-1:0] TMO_CYC = 24'd10_000_000
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       START,
    input  logic       NEW_MAX,
    input  logic       LIM_H_LO,
    input  logic       LIM_H_HI,
    input  logic       LIM_V_LO,
    input  logic       LIM_V_HI,
    input  logic       CNT_RU,
    output logic       MC,
    output logic       CNT_RST,
    output logic [1:0] H_DIR,
    output logic [1:0] V_DIR,
    output logic [2:0] STATE,
    output logic       DONE,
    output logic       ERR
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_H_HOME  = 3'd1,
        S_H_SWEEP = 3'd2,
        S_H_MAX   = 3'd3,
        S_V_HOME  = 3'd4,
        S_V_SWEEP = 3'd5,
        S_V_MAX   = 3'd6,
        S_MAN     = 3'd7
    } state_t;

    localparam logic [1:0]       DIR_HOLD  = 2'b00;
    localparam logic [1:0]       DIR_INC   = 2'b01;
    localparam logic [1:0]       DIR_DEC   = 2'b10;
    localparam logic [TMO_W-1:0] WDOG_ZERO = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0] WDOG_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] WDOG_LAST = TMO_CYC - WDOG_ONE;
    localparam logic [TMO_W-1:0] WDOG_SAT  = {TMO_W{1'b1}};

    state_t           r_state;
    state_t           w_next;
    logic             r_grace;
    logic             w_grace;
    logic [TMO_W-1:0] r_wdog;
    logic [TMO_W-1:0] w_wdog;
    logic             r_mc;
    logic             w_mc;
    logic             r_cnt_rst;
    logic             w_cnt_rst;
    logic [1:0]       r_h_dir;
    logic [1:0]       w_h_dir;
    logic [1:0]       r_v_dir;
    logic [1:0]       w_v_dir;
    logic             r_done;
    logic             w_done;
    logic             r_err;
    logic             w_err;
    logic             w_tracking;
    logic             w_timeout;
    logic             w_parked;

    // Watchdog status: only HOME/SWEEP/MAX states are time-limited
    always_comb begin
        w_parked   = (r_state == S_IDLE) || (r_state == S_MAN);
        w_tracking = !w_parked;
        w_timeout  = w_tracking && (r_wdog >= WDOG_LAST);
    end

    // Next-state selection; a watchdog abort overrides every normal exit
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_MAN: begin
                if (START) w_next = S_H_HOME;
                else       w_next = r_state;
            end
            S_H_HOME: begin
                if (w_timeout)     w_next = S_MAN;
                else if (LIM_H_LO) w_next = S_H_SWEEP;
                else               w_next = S_H_HOME;
            end
            S_H_SWEEP: begin
                if (w_timeout)     w_next = S_MAN;
                else if (LIM_H_HI) w_next = S_H_MAX;
                else               w_next = S_H_SWEEP;
            end
            S_H_MAX: begin
                if (w_timeout)               w_next = S_MAN;
                else if (r_grace && !CNT_RU) w_next = S_V_HOME;
                else                         w_next = S_H_MAX;
            end
            S_V_HOME: begin
                if (w_timeout)     w_next = S_MAN;
                else if (LIM_V_LO) w_next = S_V_SWEEP;
                else               w_next = S_V_HOME;
            end
            S_V_SWEEP: begin
                if (w_timeout)     w_next = S_MAN;
                else if (LIM_V_HI) w_next = S_V_MAX;
                else               w_next = S_V_SWEEP;
            end
            S_V_MAX: begin
                if (w_timeout)               w_next = S_MAN;
                else if (r_grace && !CNT_RU) w_next = S_MAN;
                else                         w_next = S_V_MAX;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output values for the upcoming state; a NEW_MAX on the last sweep cycle
    // still clears the counter, on the first MAX cycle, giving a zero return count
    always_comb begin
        w_mc      = 1'b0;
        w_cnt_rst = 1'b1;
        w_h_dir   = DIR_HOLD;
        w_v_dir   = DIR_HOLD;
        case (w_next)
            S_H_HOME: w_h_dir = DIR_DEC;
            S_H_SWEEP: begin
                w_h_dir   = DIR_INC;
                w_cnt_rst = (r_state != S_H_SWEEP) || NEW_MAX;
            end
            S_H_MAX: begin
                w_h_dir   = DIR_DEC;
                w_mc      = 1'b1;
                w_cnt_rst = (r_state == S_H_SWEEP) && NEW_MAX;
            end
            S_V_HOME: w_v_dir = DIR_DEC;
            S_V_SWEEP: begin
                w_v_dir   = DIR_INC;
                w_cnt_rst = (r_state != S_V_SWEEP) || NEW_MAX;
            end
            S_V_MAX: begin
                w_v_dir   = DIR_DEC;
                w_mc      = 1'b1;
                w_cnt_rst = (r_state == S_V_SWEEP) && NEW_MAX;
            end
            default: begin
                w_mc      = 1'b0;
                w_cnt_rst = 1'b1;
            end
        endcase

        w_done  = (r_state == S_V_MAX) && (w_next == S_MAN) && !w_timeout;
        w_grace = ((r_state == S_H_MAX) || (r_state == S_V_MAX)) && (w_next == r_state);

        if (w_next != r_state)                        w_wdog = WDOG_ZERO;
        else if (w_tracking && (r_wdog != WDOG_SAT))  w_wdog = r_wdog + WDOG_ONE;
        else                                          w_wdog = r_wdog;

        if (w_timeout)             w_err = 1'b1;
        else if (w_parked && START) w_err = 1'b0;
        else                       w_err = r_err;
    end

    // State, watchdog and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state   <= S_IDLE;
            r_grace   <= 1'b0;
            r_wdog    <= WDOG_ZERO;
            r_mc      <= 1'b0;
            r_cnt_rst <= 1'b1;
            r_h_dir   <= DIR_HOLD;
            r_v_dir   <= DIR_HOLD;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_grace   <= w_grace;
            r_wdog    <= w_wdog;
            r_mc      <= w_mc;
            r_cnt_rst <= w_cnt_rst;
            r_h_dir   <= w_h_dir;
            r_v_dir   <= w_v_dir;
            r_done    <= w_done;
            r_err     <= w_err;
        end
    end

    assign MC      = r_mc;
    assign CNT_RST = r_cnt_rst;
    assign H_DIR   = r_h_dir;
    assign V_DIR   = r_v_dir;
    assign STATE   = r_state;
    assign DONE    = r_done;
    assign ERR     = r_err;

endmodule

// File: tb/tb_tracker_fsm.sv
// Directed bench for tracker_fsm: vector table plus multi-cycle sequences,
// with a behavioural max counter closing the CNT_RU loop.
module tb_tracker_fsm;

    logic       clk;
    logic       rstn, start, new_max;
    logic       lim_h_lo, lim_h_hi, lim_v_lo, lim_v_hi;
    logic       cnt_ru;
    logic       mc, cnt_rst, done, err;
    logic [1:0] h_dir, v_dir;
    logic [2:0] state;
    logic       wd_mc, wd_cnt_rst, wd_done, wd_err;
    logic [1:0] wd_h_dir, wd_v_dir;
    logic [2:0] wd_state;

    int n_cmp = 0;
    int n_bad = 0;

    tracker_fsm #(.TMO_W(24), .TMO_CYC(24'd1000)) dut (
        .CLK(clk), .RSTN(rstn), .START(start), .NEW_MAX(new_max),
        .LIM_H_LO(lim_h_lo), .LIM_H_HI(lim_h_hi), .LIM_V_LO(lim_v_lo), .LIM_V_HI(lim_v_hi),
        .CNT_RU(cnt_ru), .MC(mc), .CNT_RST(cnt_rst), .H_DIR(h_dir), .V_DIR(v_dir),
        .STATE(state), .DONE(done), .ERR(err)
    );

    tracker_fsm #(.TMO_W(24), .TMO_CYC(24'd50)) dut_wd (
        .CLK(clk), .RSTN(rstn), .START(start), .NEW_MAX(new_max),
        .LIM_H_LO(lim_h_lo), .LIM_H_HI(lim_h_hi), .LIM_V_LO(lim_v_lo), .LIM_V_HI(lim_v_hi),
        .CNT_RU(cnt_ru), .MC(wd_mc), .CNT_RST(wd_cnt_rst), .H_DIR(wd_h_dir), .V_DIR(wd_v_dir),
        .STATE(wd_state), .DONE(wd_done), .ERR(wd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Max counter model: sees MC one cycle late, clear has priority
    logic [15:0] m_cnt = 16'd0;
    logic        m_mcq = 1'b0;
    assign cnt_ru = (m_cnt != 16'd0);
    always @(posedge clk) begin
        m_mcq <= mc;
        if (cnt_rst)             m_cnt <= 16'd0;
        else if (!m_mcq)         m_cnt <= m_cnt + 16'd1;
        else if (m_cnt != 16'd0) m_cnt <= m_cnt - 16'd1;
    end

    typedef struct {
        logic        rstn, start, nm, hlo, hhi, vlo, vhi;
        logic [10:0] exp; // {state, h_dir, v_dir, mc, cnt_rst, done, err}
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic add(input logic r, s, nm, hlo, hhi, vlo, vhi,
                       input logic [2:0] st, input logic [1:0] hd, vd,
                       input logic m, cr, d, e);
        vec_t v;
        v.rstn = r; v.start = s; v.nm = nm; v.hlo = hlo; v.hhi = hhi; v.vlo = vlo; v.vhi = vhi;
        v.exp = {st, hd, vd, m, cr, d, e};
        vecs.push_back(v);
    endtask

    // One axis: home for 5 cycles, sweep 101 cycles with NEW_MAX at 40, return
    task automatic axis_pass(input bit vert, output int max_len);
        repeat (4) @(negedge clk);
        if (vert) lim_v_lo = 1'b1; else lim_h_lo = 1'b1;
        @(negedge clk);
        lim_v_lo = 1'b0; lim_h_lo = 1'b0;
        check(vert ? "v_sweep_entry" : "h_sweep_entry", 32'({state, h_dir, v_dir}),
              vert ? 32'({3'd5, 2'b00, 2'b01}) : 32'({3'd2, 2'b01, 2'b00}));
        for (int s = 0; s <= 100; s++) begin
            new_max = (s == 40);
            if (vert) lim_v_hi = (s == 100); else lim_h_hi = (s == 100);
            @(negedge clk);
        end
        new_max = 1'b0; lim_h_hi = 1'b0; lim_v_hi = 1'b0;
        check(vert ? "v_max_dir" : "h_max_dir", 32'({mc, h_dir, v_dir}),
              vert ? 32'({1'b1, 2'b00, 2'b10}) : 32'({1'b1, 2'b10, 2'b00}));
        max_len = 0;
        while ((state == (vert ? 3'd6 : 3'd3)) && (max_len < 500)) begin
            max_len++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end, expected finish");
        $fatal(1);
    end

    initial begin
        int len;
        int bad_cycles;
        rstn = 1'b0; start = 1'b1; new_max = 1'b0;
        lim_h_lo = 1'b0; lim_h_hi = 1'b0; lim_v_lo = 1'b0; lim_v_hi = 1'b0;

        //   rstn st  nm  hlo hhi vlo vhi | state hdir  vdir  mc  crst done err
        add(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0);
        add(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd1,2'b10,2'b00,1'b0,1'b1,1'b0,1'b0);
        add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 3'd1,2'b10,2'b00,1'b0,1'b1,1'b0,1'b0);
        add(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 3'd2,2'b01,2'b00,1'b0,1'b1,1'b0,1'b0);
        add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd2,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0);
        add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 3'd2,2'b01,2'b00,1'b0,1'b1,1'b0,1'b0);
        add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd2,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0);
        add(1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 3'd3,2'b10,2'b00,1'b1,1'b1,1'b0,1'b0);
        add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 3'd3,2'b10,2'b00,1'b1,1'b0,1'b0,1'b0);
        add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd4,2'b00,2'b10,1'b0,1'b1,1'b0,1'b0);
        add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd5,2'b00,2'b01,1'b0,1'b1,1'b0,1'b0);
        add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 3'd6,2'b00,2'b10,1'b1,1'b1,1'b0,1'b0);
        add(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 3'd6,2'b00,2'b10,1'b1,1'b0,1'b0,1'b0);
        add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd7,2'b00,2'b00,1'b0,1'b1,1'b1,1'b0);
        add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd7,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0);
        add(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd1,2'b10,2'b00,1'b0,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            rstn = vecs[i].rstn; start = vecs[i].start; new_max = vecs[i].nm;
            lim_h_lo = vecs[i].hlo; lim_h_hi = vecs[i].hhi;
            lim_v_lo = vecs[i].vlo; lim_v_hi = vecs[i].vhi;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  32'({state, h_dir, v_dir, mc, cnt_rst, done, err}), 32'(vecs[i].exp));
        end
        start = 1'b0; new_max = 1'b0;
        lim_h_lo = 1'b0; lim_h_hi = 1'b0; lim_v_lo = 1'b0; lim_v_hi = 1'b0;

        // Full two-axis run
        rstn = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("run_start", 32'({state, h_dir}), 32'({3'd1, 2'b10}));
        axis_pass(1'b0, len);
        check("h_max_len", 32'(len), 32'd62);
        check("v_home_entry", 32'({state, h_dir, v_dir}), 32'({3'd4, 2'b00, 2'b10}));
        axis_pass(1'b1, len);
        check("v_max_len", 32'(len), 32'd62);
        check("done_pulse", 32'({state, done, err}), 32'({3'd7, 1'b1, 1'b0}));
        @(negedge clk);
        check("done_clear", 32'({state, done}), 32'({3'd7, 1'b0}));

        // MAN holds without START
        bad_cycles = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if ((state != 3'd7) || (done != 1'b0) || (h_dir != 2'b00) || (v_dir != 2'b00))
                bad_cycles++;
        end
        check("man_hold", 32'(bad_cycles), 32'd0);

        // Re-track from MAN
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("retrack", 32'({state, h_dir, err}), 32'({3'd1, 2'b10, 1'b0}));

        // Reset in the middle of V_SWEEP
        lim_h_lo = 1'b1; @(negedge clk); lim_h_lo = 1'b0;
        new_max = 1'b1; lim_h_hi = 1'b1; @(negedge clk); new_max = 1'b0; lim_h_hi = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_v_home", 32'(state), 32'd4);
        lim_v_lo = 1'b1; @(negedge clk); lim_v_lo = 1'b0;
        @(negedge clk);
        check("mid_v_sweep", 32'({state, v_dir}), 32'({3'd5, 2'b01}));
        rstn = 1'b0;
        @(negedge clk);
        check("mid_reset", 32'({state, v_dir, cnt_rst, mc}), 32'({3'd0, 2'b00, 1'b1, 1'b0}));

        // Watchdog abort in H_SWEEP on the short-timeout instance
        rstn = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        lim_h_lo = 1'b1; @(negedge clk); lim_h_lo = 1'b0;
        check("wd_sweep", 32'(wd_state), 32'd2);
        len = 0;
        while ((wd_state == 3'd2) && (len < 200)) begin
            len++;
            @(negedge clk);
        end
        check("wd_cycles", 32'(len), 32'd50);
        check("wd_abort", 32'({wd_state, wd_err, wd_done, wd_h_dir, wd_v_dir}),
              32'({3'd7, 1'b1, 1'b0, 2'b00, 2'b00}));
        check("wd_main_alive", 32'({state, err}), 32'({3'd2, 1'b0}));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("wd_err_clear", 32'({wd_state, wd_err}), 32'({3'd1, 1'b0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
